binary_matvec_seq: RTL and testbench

- Sequential, parametrised N x N binary matrix-vector multiplier, u = A·v, for the binary_matrix library.
- Vector v is latched on start. Matrix rows stream in one per valid/ready handshake, and one result bit is produced per accepted row.
- Two selectable reductions: GF(2) (AND then XOR) or boolean semiring (AND then OR).
- Result vector is presented on a valid/ready output handshake.

---
 rtl/binary_matvec_seq.sv | 118 +++++++++++
 tb/tb_binary_matvec_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/binary_matvec_seq.sv
// Sequential N x N binary matrix-vector product u = A.v, one row per handshake, GF(2) or OR reduction.
// Optional out_par (XOR of out_u) enabled by defining BINMV_PARITY_EN.
module binary_matvec_seq #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [N-1:0]     vec_in,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic [N-1:0]     row_data,
  output logic [IDX_W-1:0] row_idx,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_u
`ifdef BINMV_PARITY_EN
  ,
  output logic             out_par
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] row_idx_q, row_idx_d;
  logic [N-1:0]     out_u_q, out_u_d;
  logic [N-1:0]     vec_q, vec_d;
  logic             mode_q, mode_d;
  logic [N-1:0]     masked;
  logic             red_bit;
  logic             load_new;

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    out_u_d   = out_u_q;
    vec_d     = vec_q;
    mode_d    = mode_q;
    load_new  = 1'b0;
    masked    = row_data & vec_q;
    red_bit   = mode_q ? (|masked) : (^masked);

    case (state_q)
      IDLE: begin
        if (start) load_new = 1'b1;
      end
      LOAD: begin
        if (row_valid) begin
          for (int r = 0; r < N; r++) begin
            if (row_idx_q == IDX_W'(r)) out_u_d[r] = red_bit;
          end
          // row_idx parks on the last row while the result waits in DONE
          if (row_idx_q == LAST_IDX) state_d = DONE;
          else                       row_idx_d = row_idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          if (start) begin
            load_new = 1'b1;
          end else begin
            state_d   = IDLE;
            row_idx_d = '0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        row_idx_d = '0;
      end
    endcase

    if (load_new) begin
      state_d   = LOAD;
      vec_d     = vec_in;
      mode_d    = mode;
      out_u_d   = '0;
      row_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_idx_q <= '0;
      out_u_q   <= '0;
      vec_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      out_u_q   <= out_u_d;
      vec_q     <= vec_d;
      mode_q    <= mode_d;
    end
  end

  assign row_ready = (state_q == LOAD);
  assign busy      = (state_q == LOAD) || (state_q == DONE);
  assign out_valid = (state_q == DONE);
  assign row_idx   = row_idx_q;
  assign out_u     = out_u_q;

`ifdef BINMV_PARITY_EN
  assign out_par = ^out_u_q;
`endif

endmodule

// File: tb/tb_binary_matvec_seq.sv
// Bench for binary_matvec_seq: N=4 instance checked every cycle against a row-count model, N=2 instance by literals.
module tb_binary_matvec_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // N=4 instance
  logic       start = 0, mode = 0, row_valid = 0, out_ready = 0;
  logic [3:0] vec_in = 0, row_data = 0;
  logic       row_ready, busy, out_valid;
  logic [1:0] row_idx;
  logic [3:0] out_u;
  // N=2 instance
  logic       start2 = 0, mode2 = 0, rv2 = 0, ordy2 = 0;
  logic [1:0] vec2 = 0, rd2 = 0;
  logic       rr2, busy2, ov2;
  logic [0:0] idx2;
  logic [1:0] u2;
`ifdef BINMV_PARITY_EN
  logic       out_par, par2;
`endif

  binary_matvec_seq #(.N(4), .IDX_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .vec_in(vec_in),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_idx(row_idx), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_u(out_u)
`ifdef BINMV_PARITY_EN
    , .out_par(out_par)
`endif
  );

  binary_matvec_seq #(.N(2), .IDX_W(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .vec_in(vec2),
    .row_valid(rv2), .row_ready(rr2), .row_data(rd2),
    .row_idx(idx2), .busy(busy2), .out_valid(ov2),
    .out_ready(ordy2), .out_u(u2)
`ifdef BINMV_PARITY_EN
    , .out_par(par2)
`endif
  );

  int n_cmp = 0, n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0=idle 1=loading 2=done; m_cnt = rows accepted so far.
  int         m_phase = 0, m_cnt = 0;
  logic [3:0] m_v = 0, m_u = 0;
  logic       m_mode = 0;

  function automatic logic red(input logic [3:0] a, input logic md);
    int c = $countones(a);
    return md ? (c > 0) : (c % 2 == 1);
  endfunction

  task automatic m_load();
    m_phase = 1; m_cnt = 0; m_v = vec_in; m_mode = mode; m_u = 4'b0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_v = 0; m_mode = 0; m_u = 0;
    end else begin
      case (m_phase)
        0: if (start) m_load();
        1: if (row_valid) begin
             m_u[m_cnt] = red(row_data & m_v, m_mode);
             m_cnt++;
             if (m_cnt == 4) m_phase = 2;
           end
        default: if (out_ready) begin
             if (start) m_load();
             else begin m_phase = 0; m_cnt = 0; end
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("row_ready", row_ready, m_phase == 1);
      chk("busy", busy, m_phase != 0);
      chk("out_valid", out_valid, m_phase == 2);
      chk("row_idx", row_idx, (m_phase == 2) ? 3 : m_cnt);
      chk("out_u", out_u, m_u);
`ifdef BINMV_PARITY_EN
      chk("out_par", out_par, ^m_u);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start4(input logic [3:0] v, input logic md);
    start = 1; vec_in = v; mode = md;
    step();
    start = 0;
  endtask

  task automatic rows4(input logic [3:0] r0, r1, r2, r3, input bit gap);
    logic [3:0] rr [4];
    rr = '{r0, r1, r2, r3};
    for (int i = 0; i < 4; i++) begin
      row_valid = 1; row_data = rr[i];
      step();
      row_valid = 0;
      if (gap) step();
    end
  endtask

  task automatic wait_valid4(input string nm);
    for (int k = 0; k < 20; k++) begin
      if (out_valid === 1'b1) break;
      step();
    end
    chk(nm, out_valid, 1);
  endtask

  task automatic handshake4();
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  task automatic run2(input logic md, input logic [1:0] exp);
    start2 = 1; vec2 = 2'b11; mode2 = md;
    step();
    start2 = 0;
    chk("n2_rdy", rr2, 1);
    rv2 = 1; rd2 = 2'b01;
    step();
    chk("n2_idx1", idx2, 1);
    rd2 = 2'b11;
    step();
    rv2 = 0;
    chk("n2_vld", ov2, 1);
    chk("n2_u", u2, exp);
    ordy2 = 1;
    step();
    ordy2 = 0;
    chk("n2_idle", busy2, 0);
  endtask

  initial begin
    repeat (2) step();
    chk("rst_u", out_u, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vld", out_valid, 0);
    rst_n = 1;
    chk_en = 1;
    step();

    // N=2 GF(2) then OR
    run2(1'b0, 2'b01);
    run2(1'b1, 2'b11);

    // identity matrix, gapped rows
    start4(4'b1011, 1'b0);
    rows4(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1'b1);
    wait_valid4("id_wait");
    chk("id_u", out_u, 4'b1011);
`ifdef BINMV_PARITY_EN
    chk("id_par", out_par, 1);
`endif

    // output backpressure: result must hold
    out_ready = 0;
    repeat (3) begin
      step();
      chk("bp_u", out_u, 4'b1011);
      chk("bp_vld", out_valid, 1);
    end

    // back-to-back restart, start pulse in LOAD ignored
    out_ready = 1; start = 1; vec_in = 4'b0001; mode = 0;
    step();
    out_ready = 0; start = 0;
    chk("b2b_rdy", row_ready, 1);
    chk("b2b_clr", out_u, 0);
    row_valid = 1; row_data = 4'b1111; step();
    start = 1; vec_in = 4'b1111; row_data = 4'b0000; step();
    start = 0; row_data = 4'b0001; step();
    row_data = 4'b1110; step();
    row_valid = 0;
    wait_valid4("b2b_wait");
    chk("b2b_u", out_u, 4'b0101);
    handshake4();
    chk("idle_busy", busy, 0);

    // OR reduction
    start4(4'b0110, 1'b1);
    rows4(4'b0001, 4'b0010, 4'b0110, 4'b1000, 1'b0);
    wait_valid4("or_wait");
    chk("or_u", out_u, 4'b0110);
    handshake4();

    // reset mid-LOAD after 2 rows
    start4(4'b1111, 1'b0);
    row_valid = 1; row_data = 4'b0001; step();
    row_data = 4'b0010; step();
    row_valid = 0;
    chk("pre_rst_u", out_u, 4'b0011);
    rst_n = 0;
    step();
    chk("mid_rst_u", out_u, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", row_ready, 0);
    chk("mid_rst_idx", row_idx, 0);
    rst_n = 1;
    step();
    start4(4'b1011, 1'b0);
    rows4(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1'b0);
    wait_valid4("fresh_wait");
    chk("fresh_u", out_u, 4'b1011);
    handshake4();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
